reg_forward_ctrl: RTL and testbench

REG_FORWARD_CTRL -- requirements
Module: reg_forward_ctrl

---
 rtl/reg_forward_ctrl_pkg.sv | 21 ++
 rtl/reg_forward_ctrl_fwd_port.sv | 41 ++++
 rtl/reg_forward_ctrl.sv | 95 +++++++++
 tb/tb_reg_forward_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_forward_ctrl_pkg.sv
// Shared definitions for the register forwarding / hazard controller:
// access-type encodings, default multi-cycle latency bound and a clog2 helper.
package reg_forward_ctrl_pkg;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_R2R  = 2'd1,
    ACC_M2R  = 2'd2,
    ACC_R2M  = 2'd3
  } acc_t;

  localparam int MAX_LAT_DEF = 7;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_forward_ctrl_fwd_port.sv
// One read port: operand forwarding mux (EX > MM > WB > regfile) plus
// load-use / scoreboard hazard detection for that port.
import reg_forward_ctrl_pkg::*;

module reg_fwd_port #(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_regval,
  input  logic [4:0]        ex_addr,
  input  logic [DATA_W-1:0] ex_val,
  input  logic [1:0]        ex_type,
  input  logic [4:0]        mm_addr,
  input  logic [DATA_W-1:0] mm_val,
  input  logic [1:0]        mm_type,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_val,
  input  logic              wb_we,
  input  logic [31:0]       busy,
  output logic [DATA_W-1:0] rd_val,
  output logic              hazard
);

  logic nz;

  always_comb begin
    nz = (rd_addr != 5'd0);
    rd_val = rd_regval;
    if (!nz)
      rd_val = '0;
    else if (rd_addr == ex_addr && ex_type == ACC_R2R)
      rd_val = ex_val;
    else if (rd_addr == mm_addr && (mm_type == ACC_R2R || mm_type == ACC_M2R))
      rd_val = mm_val;
    else if (rd_addr == wb_addr && wb_we)
      rd_val = wb_val;
    // A load in EX has no data yet; a busy multi-cycle result is not ready either.
    hazard = nz && ((rd_addr == ex_addr && ex_type == ACC_M2R) || busy[rd_addr]);
  end

endmodule

// File: rtl/reg_forward_ctrl.sv
// Register forwarding and stall controller with a multi-cycle scoreboard.
// Optional stall statistics counter enabled by defining REG_FWD_STATS_EN.
import reg_forward_ctrl_pkg::*;

module reg_forward_ctrl #(
  parameter int NUM_RD  = 2,
  parameter int DATA_W  = 32,
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int LAT_W   = clog2(MAX_LAT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*5-1:0]      rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] rd_regval,
  input  logic [4:0]               ex_addr,
  input  logic [DATA_W-1:0]        ex_val,
  input  logic [1:0]               ex_type,
  input  logic [4:0]               mm_addr,
  input  logic [DATA_W-1:0]        mm_val,
  input  logic [1:0]               mm_type,
  input  logic [4:0]               wb_addr,
  input  logic [DATA_W-1:0]        wb_val,
  input  logic                     wb_we,
  input  logic                     mc_issue,
  input  logic [4:0]               mc_addr,
  input  logic [LAT_W-1:0]         mc_lat,
  input  logic                     flush,
  output logic [NUM_RD*DATA_W-1:0] rd_val,
  output logic                     stall,
  output logic [31:0]              stall_cnt
);

  logic [LAT_W-1:0]  cnt [1:31];
  logic [31:0]       busy;
  logic [NUM_RD-1:0] hz;
  logic [LAT_W:0]    lat_ext;
  logic [LAT_W-1:0]  lat_load;
  logic              issue_ok;

  // Out-of-range latencies clamp to MAX_LAT; the extra bit keeps the compare meaningful.
  always_comb begin
    lat_ext  = {1'b0, mc_lat};
    lat_load = (lat_ext > (LAT_W+1)'(MAX_LAT)) ? LAT_W'(MAX_LAT) : mc_lat;
    issue_ok = mc_issue && (mc_addr != 5'd0) && (mc_lat != '0);
  end

  always_ff @(posedge clk) begin
    for (int r = 1; r < 32; r++) begin
      if (rst || flush)
        cnt[r] <= '0;
      else if (issue_ok && mc_addr == 5'(r))
        cnt[r] <= lat_load;
      else if (cnt[r] != '0)
        cnt[r] <= cnt[r] - LAT_W'(1);
    end
  end

  always_comb begin
    busy[0] = 1'b0;
    for (int r = 1; r < 32; r++) busy[r] = (cnt[r] != '0);
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    reg_fwd_port #(.DATA_W(DATA_W)) u_port (
      .rd_addr   (rd_addr[p*5 +: 5]),
      .rd_regval (rd_regval[p*DATA_W +: DATA_W]),
      .ex_addr   (ex_addr),
      .ex_val    (ex_val),
      .ex_type   (ex_type),
      .mm_addr   (mm_addr),
      .mm_val    (mm_val),
      .mm_type   (mm_type),
      .wb_addr   (wb_addr),
      .wb_val    (wb_val),
      .wb_we     (wb_we),
      .busy      (busy),
      .rd_val    (rd_val[p*DATA_W +: DATA_W]),
      .hazard    (hz[p])
    );
  end

  assign stall = |hz;

`ifdef REG_FWD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall)
      stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_reg_forward_ctrl.sv
// Self-checking bench for reg_forward_ctrl: forwarding vector table, directed
// multi-cycle sequences and randomized traffic against a cycle-count reference.
module tb_reg_forward_ctrl;

  localparam int NUM_RD = 2;
  localparam int DATA_W = 32;
  localparam int MAX_LAT = 7;
  localparam int LAT_W = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD*5-1:0]      rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_regval;
  logic [4:0]               ex_addr, mm_addr, wb_addr, mc_addr;
  logic [DATA_W-1:0]        ex_val, mm_val, wb_val;
  logic [1:0]               ex_type, mm_type;
  logic                     wb_we, mc_issue, flush;
  logic [LAT_W-1:0]         mc_lat;
  logic [NUM_RD*DATA_W-1:0] rd_val;
  logic                     stall;
  logic [31:0]              stall_cnt;

  reg_forward_ctrl #(.NUM_RD(NUM_RD), .DATA_W(DATA_W), .MAX_LAT(MAX_LAT)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_regval(rd_regval),
    .ex_addr(ex_addr), .ex_val(ex_val), .ex_type(ex_type),
    .mm_addr(mm_addr), .mm_val(mm_val), .mm_type(mm_type),
    .wb_addr(wb_addr), .wb_val(wb_val), .wb_we(wb_we),
    .mc_issue(mc_issue), .mc_addr(mc_addr), .mc_lat(mc_lat),
    .flush(flush), .rd_val(rd_val), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: each register is busy up to and including an absolute cycle number.
  int cyc = 0;
  int busy_until [32];
  int m_scnt = 0;

  typedef struct {
    logic [4:0] a0, a1, ea; logic [1:0] et;
    logic [4:0] ma; logic [1:0] mt; logic [4:0] wa; logic we;
    logic [31:0] e0, e1; logic es;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic m_busy(input logic [4:0] a);
    return (a != 5'd0) && (cyc <= busy_until[a]);
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] rv);
    if (a == 5'd0) return 32'd0;
    if (a == ex_addr && ex_type == 2'd1) return ex_val;
    if (a == mm_addr && (mm_type == 2'd1 || mm_type == 2'd2)) return mm_val;
    if (a == wb_addr && wb_we) return wb_val;
    return rv;
  endfunction

  function automatic logic m_stall();
    logic s;
    s = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [4:0] a;
      a = rd_addr[p*5 +: 5];
      if (a != 5'd0 && ((a == ex_addr && ex_type == 2'd2) || m_busy(a))) s = 1'b1;
    end
    return s;
  endfunction

  task automatic clr_in();
    rd_addr = '0; rd_regval = {32'h22, 32'h11};
    ex_addr = 0; ex_val = 32'hE0; ex_type = 0;
    mm_addr = 0; mm_val = 32'h30; mm_type = 0;
    wb_addr = 0; wb_val = 32'hB0; wb_we = 0;
    mc_issue = 0; mc_addr = 0; mc_lat = 0; flush = 0; rst = 0;
  endtask

  task automatic settle_chk();
    #1;
    chk("rd_val0", rd_val[31:0],  m_fwd(rd_addr[4:0], rd_regval[31:0]));
    chk("rd_val1", rd_val[63:32], m_fwd(rd_addr[9:5], rd_regval[63:32]));
    chk("stall", {31'd0, stall}, {31'd0, m_stall()});
    chk("stall_cnt", stall_cnt, m_scnt);
  endtask

  task automatic tick();
    logic s;
    int lat;
    s = m_stall();
    @(posedge clk);
    if (rst || flush) begin
      for (int r = 0; r < 32; r++) busy_until[r] = -1;
    end else if (mc_issue && mc_addr != 0 && mc_lat != 0) begin
      lat = (int'(mc_lat) > MAX_LAT) ? MAX_LAT : int'(mc_lat);
      busy_until[mc_addr] = cyc + lat;
    end
`ifdef REG_FWD_STATS_EN
    if (rst) m_scnt = 0;
    else if (s) m_scnt = m_scnt + 1;
`endif
    cyc++;
    #1;
  endtask

  // Drive one directed cycle: model compare, explicit stall expectation, then clock.
  task automatic dstep(input string nm, input logic exp_stall);
    settle_chk();
    chk(nm, {31'd0, stall}, {31'd0, exp_stall});
    tick();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) busy_until[r] = -1;
    tbl[0] = '{5'd5, 5'd6, 5'd5, 2'd1, 5'd5, 2'd1, 5'd6, 1'b1, 32'hE0, 32'hB0, 1'b0};
    tbl[1] = '{5'd0, 5'd0, 5'd0, 2'd1, 5'd0, 2'd1, 5'd0, 1'b1, 32'h0,  32'h0,  1'b0};
    tbl[2] = '{5'd3, 5'd4, 5'd3, 2'd2, 5'd4, 2'd2, 5'd0, 1'b0, 32'h11, 32'h30, 1'b1};
    tbl[3] = '{5'd3, 5'd3, 5'd3, 2'd3, 5'd3, 2'd3, 5'd3, 1'b1, 32'hB0, 32'hB0, 1'b0};
    tbl[4] = '{5'd3, 5'd4, 5'd3, 2'd0, 5'd3, 2'd2, 5'd4, 1'b0, 32'h30, 32'h22, 1'b0};
    tbl[5] = '{5'd7, 5'd7, 5'd7, 2'd1, 5'd7, 2'd2, 5'd0, 1'b0, 32'hE0, 32'hE0, 1'b0};
    tbl[6] = '{5'd9, 5'd2, 5'd2, 2'd2, 5'd0, 2'd0, 5'd0, 1'b0, 32'h11, 32'h22, 1'b1};
    tbl[7] = '{5'd0, 5'd1, 5'd0, 2'd2, 5'd1, 2'd1, 5'd0, 1'b0, 32'h0,  32'h30, 1'b0};

    clr_in();
    rst = 1;
    @(posedge clk); #1;
    tick(); tick();
    rst = 0;
    settle_chk();
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_stall_cnt", stall_cnt, 32'd0);

    // Forwarding priority table
    for (int i = 0; i < 8; i++) begin
      clr_in();
      rd_addr = {tbl[i].a1, tbl[i].a0};
      ex_addr = tbl[i].ea; ex_type = tbl[i].et;
      mm_addr = tbl[i].ma; mm_type = tbl[i].mt;
      wb_addr = tbl[i].wa; wb_we = tbl[i].we;
      settle_chk();
      chk($sformatf("tbl%0d_val0", i), rd_val[31:0], tbl[i].e0);
      chk($sformatf("tbl%0d_val1", i), rd_val[63:32], tbl[i].e1);
      chk($sformatf("tbl%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].es});
      tick();
    end

    // Load-use then forwarded from MM
    clr_in(); rd_addr = {5'd7, 5'd0}; ex_addr = 7; ex_type = 2;
    dstep("lu_stall", 1'b1);
    clr_in(); rd_addr = {5'd7, 5'd0}; mm_addr = 7; mm_type = 2; mm_val = 32'h1234;
    settle_chk();
    chk("lu_fwd_val1", rd_val[63:32], 32'h1234);
    chk("lu_fwd_stall", {31'd0, stall}, 32'd0);
    tick();

    // Multi-cycle issue lat 3: exactly 3 stalled cycles
    clr_in(); rd_addr = {5'd0, 5'd9}; mc_issue = 1; mc_addr = 9; mc_lat = 3;
    dstep("mc3_issue", 1'b0);
    mc_issue = 0;
    for (int k = 0; k < 3; k++) dstep($sformatf("mc3_busy%0d", k), 1'b1);
    dstep("mc3_done", 1'b0);

    // Reissue lat 5 one cycle later: 5 more stalled cycles
    mc_issue = 1; mc_lat = 3;
    dstep("re_issue", 1'b0);
    mc_lat = 5;
    dstep("re_issue2", 1'b1);
    mc_issue = 0;
    for (int k = 0; k < 5; k++) dstep($sformatf("re_busy%0d", k), 1'b1);
    dstep("re_done", 1'b0);

    // Flush mid-count, flush beats issue, rst beats issue, lat 0 / addr 0 ignored
    mc_issue = 1; mc_lat = 6;
    dstep("fl_issue", 1'b0);
    mc_issue = 0;
    dstep("fl_busy", 1'b1);
    flush = 1;
    dstep("fl_flush", 1'b1);
    flush = 0;
    dstep("fl_after", 1'b0);
    flush = 1; mc_issue = 1; mc_lat = 4;
    dstep("fl_vs_issue", 1'b0);
    flush = 0; mc_issue = 0;
    dstep("fl_vs_issue_after", 1'b0);
    rst = 1; flush = 1; mc_issue = 1; mc_lat = 4;
    dstep("rst_vs_issue", 1'b0);
    rst = 0; flush = 0; mc_lat = 0;
    dstep("lat0_issue", 1'b0);
    mc_issue = 0;
    dstep("lat0_after", 1'b0);
    mc_issue = 1; mc_addr = 0; mc_lat = 5; rd_addr = {5'd0, 5'd0}; wb_we = 1;
    dstep("addr0_issue", 1'b0);
    mc_issue = 0;
    chk("addr0_val0", rd_val[31:0], 32'd0);
    dstep("addr0_after", 1'b0);

    // Stall statistics: 4 stalled cycles then rst
    clr_in(); rst = 1; tick(); rst = 0;
    rd_addr = {5'd0, 5'd3}; ex_addr = 3; ex_type = 2;
    for (int k = 0; k < 4; k++) dstep("st_stall", 1'b1);
    clr_in(); rst = 1;
    settle_chk();
`ifdef REG_FWD_STATS_EN
    chk("st_cnt4", stall_cnt, 32'd4);
`else
    chk("st_cnt4", stall_cnt, 32'd0);
`endif
    tick(); rst = 0;
    settle_chk();
    chk("st_cnt_rst", stall_cnt, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rd_regval = {32'($urandom), 32'($urandom)};
      ex_addr = 5'($urandom_range(0, 7)); ex_val = $urandom; ex_type = 2'($urandom);
      mm_addr = 5'($urandom_range(0, 7)); mm_val = $urandom; mm_type = 2'($urandom);
      wb_addr = 5'($urandom_range(0, 7)); wb_val = $urandom; wb_we = 1'($urandom);
      mc_issue = ($urandom_range(0, 2) == 0);
      mc_addr = 5'($urandom_range(0, 7)); mc_lat = 3'($urandom);
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      settle_chk();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
